// File: rtl/fence_flush_ctrl.sv
// Flush/fence controller: drives stage, predictor, I$ and TLB flushes and drains
// the accelerator store channels plus D$ on FENCE. Optional drain timeout: FENCE_TIMEOUT_EN.
module fence_flush_ctrl #(
   parameter int unsigned NrAccPorts    = 2,
   parameter bit          WriteThrough  = 1'b0,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  mispredict_i,
   input  logic                  fence_i,
   input  logic                  fence_i_i,
   input  logic                  sfence_vma_i,
   input  logic                  flush_csr_i,
   input  logic                  flush_commit_i,
   input  logic                  ex_valid_i,
   input  logic                  eret_i,
   input  logic                  set_debug_pc_i,
   input  logic                  halt_csr_i,
   input  logic                  flush_dcache_ack_i,
   input  logic [NrAccPorts-1:0] acc_store_pending_i,
   output logic                  set_pc_commit_o,
   output logic                  flush_if_o,
   output logic                  flush_unissued_instr_o,
   output logic                  flush_id_o,
   output logic                  flush_ex_o,
   output logic                  flush_bp_o,
   output logic                  flush_icache_o,
   output logic                  flush_tlb_o,
   output logic                  flush_dcache_o,
   output logic                  halt_o,
   output logic [NrAccPorts-1:0] acc_wait_o,
   output logic                  fence_done_o,
   output logic                  fence_timeout_o
);

   if (NrAccPorts < 1 || NrAccPorts > 8 || TimeoutCycles < 1) begin : g_param_err
      $error("fence_flush_ctrl: NrAccPorts must be 1..8 and TimeoutCycles >= 1");
   end

   typedef enum logic [1:0] {IDLE, DRAIN, RELEASE} state_e;

   state_e                state_q, state_d;
   logic [NrAccPorts-1:0] acc_pend_q, acc_pend_d;
   logic                  dc_busy_q, dc_busy_d;
   logic                  flush_dc_q, flush_dc_d;
   logic                  done_q, done_d;
   logic                  tmo_q, tmo_d;
   logic                  start;
   logic                  tmo_hit;

   assign start = fence_i | fence_i_i;

`ifdef FENCE_TIMEOUT_EN
   localparam int CntW = $clog2(TimeoutCycles + 1);

   logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;

   assign cnt_inc = cnt_q + 1'b1;
   assign tmo_hit = (state_q == DRAIN) && (cnt_inc == CntW'(TimeoutCycles));

   always_comb begin
      cnt_d = cnt_q;
      if (start) begin
         cnt_d = '0;
      end else if (state_q == DRAIN) begin
         cnt_d = cnt_inc;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // Later rules override earlier ones; exception/debug redirects win outright.
   always_comb begin
      set_pc_commit_o        = 1'b0;
      flush_if_o             = 1'b0;
      flush_unissued_instr_o = 1'b0;
      flush_id_o             = 1'b0;
      flush_ex_o             = 1'b0;
      flush_bp_o             = 1'b0;
      flush_icache_o         = 1'b0;
      flush_tlb_o            = 1'b0;
      if (mispredict_i) begin
         flush_if_o             = 1'b1;
         flush_unissued_instr_o = 1'b1;
      end
      if (fence_i || fence_i_i || sfence_vma_i || flush_csr_i || flush_commit_i) begin
         set_pc_commit_o        = 1'b1;
         flush_if_o             = 1'b1;
         flush_unissued_instr_o = 1'b1;
         flush_id_o             = 1'b1;
         flush_ex_o             = 1'b1;
      end
      if (fence_i_i) begin
         flush_icache_o = 1'b1;
      end
      if (sfence_vma_i) begin
         flush_tlb_o = 1'b1;
      end
      if (ex_valid_i || eret_i || set_debug_pc_i) begin
         set_pc_commit_o        = 1'b0;
         flush_if_o             = 1'b1;
         flush_unissued_instr_o = 1'b1;
         flush_id_o             = 1'b1;
         flush_ex_o             = 1'b1;
         flush_bp_o             = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      acc_pend_d = acc_pend_q;
      dc_busy_d  = dc_busy_q;
      done_d     = 1'b0;
      tmo_d      = 1'b0;
      flush_dc_d = (start & !WriteThrough) | (dc_busy_q & !flush_dcache_ack_i);
      case (state_q)
         IDLE, RELEASE: begin
            state_d = IDLE;
            if (start) begin
               acc_pend_d = acc_store_pending_i;
               dc_busy_d  = !WriteThrough;
               state_d    = DRAIN;
            end
         end
         DRAIN: begin
            if (start) begin
               // A fence merged mid-drain re-arms the D$ flush even if acked now.
               acc_pend_d = acc_pend_q | acc_store_pending_i;
               dc_busy_d  = !WriteThrough;
            end else if (acc_pend_q == '0 && !dc_busy_q) begin
               state_d = RELEASE;
               done_d  = 1'b1;
            end else if (tmo_hit) begin
               acc_pend_d = '0;
               dc_busy_d  = 1'b0;
               state_d    = RELEASE;
               done_d     = 1'b1;
               tmo_d      = 1'b1;
            end else begin
               acc_pend_d = acc_pend_q & acc_store_pending_i;
               dc_busy_d  = dc_busy_q & !flush_dcache_ack_i;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         acc_pend_q <= '0;
         dc_busy_q  <= 1'b0;
         flush_dc_q <= 1'b0;
         done_q     <= 1'b0;
         tmo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_pend_q <= acc_pend_d;
         dc_busy_q  <= dc_busy_d;
         flush_dc_q <= flush_dc_d;
         done_q     <= done_d;
         tmo_q      <= tmo_d;
      end
   end

   assign flush_dcache_o  = flush_dc_q;
   assign acc_wait_o      = acc_pend_q;
   assign fence_done_o    = done_q;
   assign fence_timeout_o = tmo_q;
   assign halt_o          = halt_csr_i | (state_q != IDLE);

endmodule

// File: doc/fence_flush_ctrl.md
Name: fence_flush_ctrl

Overview:
Parametrised pipeline flush and fence controller. Successor to the single-accelerator flush controller.
- Drains N accelerator store channels and the D$ concurrently, with per-channel pending tracking and fence merging.
- Write-through mode is a parameter, not a macro.
- Sits between commit/CSR/EX and the frontend, scoreboard, caches and TLBs.

Parameters:
NrAccPorts, 2, number of accelerator store channels (1..8)
WriteThrough, 1'b0, 1 = D$ needs no flush on fence; D$ drain skipped
TimeoutCycles, 1024, fence drain limit in cycles (used only with FENCE_TIMEOUT_EN); counter width $clog2(TimeoutCycles+1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
mispredict_i  in  1  resolved branch mispredicted
fence_i  in  1  FENCE committed
fence_i_i  in  1  FENCE.I committed
sfence_vma_i  in  1  SFENCE.VMA committed
flush_csr_i  in  1  CSR side-effect flush
flush_commit_i  in  1  commit-stage flush request
ex_valid_i  in  1  exception taken
eret_i  in  1  return from exception
set_debug_pc_i  in  1  debug entry
halt_csr_i  in  1  WFI halt
flush_dcache_ack_i  in  1  D$ flush complete
acc_store_pending_i  in  NrAccPorts  per-channel store outstanding
set_pc_commit_o  out  1  PC gen takes commit PC+4
flush_if_o / flush_unissued_instr_o / flush_id_o / flush_ex_o  out  1 each  stage flushes
flush_bp_o / flush_icache_o / flush_tlb_o  out  1 each  predictor / I$ / TLB flush
flush_dcache_o  out  1  registered D$ flush request
halt_o  out  1  halt commit
acc_wait_o  out  NrAccPorts  channels still being waited on
fence_done_o  out  1  one-cycle pulse when drain completes
fence_timeout_o  out  1  one-cycle pulse on drain abort (0 without macro)

Behaviour:
- Reset values:
  - all outputs 0
  - state IDLE
  - dc_busy_q=0, acc_pend_q=0, counter 0
- Combinational flush outputs use last-writer-wins priority, lowest first:
  1. mispredict_i: flush_if, flush_unissued.
  2. fence_i: set_pc_commit, flush_if, flush_unissued, flush_id, flush_ex.
  3. fence_i_i: same as fence_i, plus flush_icache_o.
  4. sfence_vma_i: as fence_i, plus flush_tlb_o; starts no drain.
  5. flush_csr_i | flush_commit_i: set_pc_commit, flush_if, flush_unissued, flush_id, flush_ex.
  6. ex_valid_i | eret_i | set_debug_pc_i: forces set_pc_commit_o=0, flush_if/unissued/id/ex=1, flush_bp_o=1.
- FSM states:
  - IDLE
    - On fence_i|fence_i_i (start): acc_pend_q <= acc_store_pending_i; dc_busy_q <= !WriteThrough; go to DRAIN.
    - If nothing is pending at start, DRAIN lasts exactly one cycle.
  - DRAIN
    - acc_pend_q[k] clears the cycle after acc_store_pending_i[k]==0; a cleared bit never re-sets except on a new fence.
    - dc_busy_q clears the cycle after flush_dcache_ack_i.
    - Next start while in DRAIN merges: acc_pend_q |= acc_store_pending_i; dc_busy_q set again (ack in the same cycle is ignored).
    - Exit to RELEASE when dc_busy_q==0 and acc_pend_q==0.
  - RELEASE: fence_done_o=1 for one cycle, then IDLE. A start in RELEASE goes directly to DRAIN and fence_done_o is still pulsed.
- flush_dcache_o is registered from (start & !WriteThrough) | (dc_busy_q & !flush_dcache_ack_i). It rises 1 cycle after the fence and falls the cycle after the ack.
- acc_wait_o = acc_pend_q.
- halt_o = halt_csr_i | (state != IDLE). RELEASE still halts, so commit resumes 1 cycle after fence_done_o.
- Async reset mid-DRAIN: immediate return to IDLE, all outputs 0; no fence_done_o pulse.

Optional Feature:
FENCE_TIMEOUT_EN
- With the macro:
  - Counter clears on start (including merges) and increments each DRAIN cycle.
  - When it reaches TimeoutCycles: fence_timeout_o pulses, acc_pend_q and dc_busy_q are forced to 0, go to RELEASE. fence_done_o is still pulsed.
- Without the macro: no counter; fence_timeout_o tied 0; DRAIN may last indefinitely.

Test Plan:
- NrAccPorts=2, WriteThrough=0. fence_i at cycle 0, pending=2'b01, dropped at cycle 3, ack at cycle 5 -> flush_dcache_o high in cycles 1–5; acc_wait_o=01 in cycles 1–3; fence_done_o at cycle 7; halt_o low at cycle 8.
- WriteThrough=1, fence_i_i with pending=2'b00 -> flush_icache_o=1 in cycle 0; flush_dcache_o never asserts; fence_done_o at cycle 2; halt_o high in cycles 1–2 only.
- Merge: fence_i in cycle 0 (pending 01). Second fence_i in cycle 4 with pending=10 while ch0 is already clear -> acc_wait_o=10 from cycle 5; exactly one fence_done_o pulse after ch1 drops.
- Priority: ex_valid_i, flush_csr_i and mispredict_i all asserted in the same cycle -> set_pc_commit_o=0; flush_if/unissued/id/ex=1; flush_bp_o=1.
- FENCE_TIMEOUT_EN, TimeoutCycles=16, pending held at 11 -> fence_timeout_o and fence_done_o pulse 16 DRAIN cycles after start; halt_o drops the next cycle.
- Reset asserted in cycle 3 of DRAIN -> halt_o, flush_dcache_o and acc_wait_o are 0 immediately; no fence_done_o pulse after reset release.
